// File: rtl/addsub_share_arbiter_pkg.sv
// Shared configuration for the add/sub sharing arbiter and the adders it fronts.
// Holds default sizes, the tag width and the round-robin increment helper.
package addsub_share_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 25;
  localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

  // Widths of the mantissa and exponent adders this block is placed in front of.
  localparam int MANT_ADD_W = 25;
  localparam int EXP_ADD_W  = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Next requester index after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/addsub_share_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the shared adder.
// valid/ready: a transfer occurs on a rising edge where both are high; valid and payload hold until then; ready never depends on its own valid except via grant.
interface addsub_share_arbiter_if
  import addsub_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_sub;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

endinterface

// File: rtl/CarryLookaheadAdder.sv
// Carry-lookahead adder built from 4-bit lookahead groups chained group to group.
// Each bit's carry is expanded from its group's incoming carry rather than rippled.
module CarryLookaheadAdder #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic             term;
  logic             acc_p;
  int               grp_base;
  int               bit_idx;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c        = '0;
    c[0]     = cin;
    term     = 1'b0;
    acc_p    = 1'b1;
    grp_base = 0;
    bit_idx  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      grp_base = i - (i % 4);
      term     = 1'b0;
      acc_p    = 1'b1;
      // Generate/propagate terms from bit i down to the group base.
      for (int j = 0; j < 4; j++) begin
        bit_idx = (j <= (i % 4)) ? (i - j) : i;
        if (j <= (i % 4)) begin
          term  = term | (acc_p & g[bit_idx]);
          acc_p = acc_p & p[bit_idx];
        end
      end
      c[i+1] = term | (acc_p & c[grp_base]);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the winner only when the caller reports a completed handshake.
module rr_arbiter
  import addsub_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [ID_W-1:0]    adv_idx,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [ID_W-1:0] ptr;
  int unsigned     scan_idx;

  always_comb begin
    any       = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[scan_idx]) begin
        any       = 1'b1;
        grant_idx = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = any && (grant_idx == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ID_W'(rr_next(int'(adv_idx), NUM_REQ));
    end
  end

endmodule

// File: rtl/addsub_share_arbiter.sv
// One adder/subtractor shared by NUM_REQ requesters: round-robin pick, operand
// register (S1), result register (S2) driving the backpressured response port.
module addsub_share_arbiter
  import addsub_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                   clk,
  input logic                   rst_n,
  addsub_share_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               any;
  logic               handshake;

  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_sub;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic               s1_sub;
  logic [ID_W-1:0]    s1_id;

  logic               s2_valid;
  logic [WIDTH-1:0]   s2_sum;
  logic               s2_cout;
  logic [ID_W-1:0]    s2_id;

  logic               s1_en;
  logic               s2_en;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  // S1 may load whenever it is empty or S2 is moving, so the pipe fills and drains on the same edge.
  assign s2_en = !s2_valid || bus.rsp_ready;
  assign s1_en = !s1_valid || s2_en;

  assign handshake     = rst_n && any && s1_en;
  assign bus.req_ready = rst_n ? (grant_onehot & {NUM_REQ{s1_en}}) : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (bus.req_valid),
    .advance      (handshake),
    .adv_idx      (grant_idx),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_a   = bus.req_a[i*WIDTH +: WIDTH];
        sel_b   = bus.req_b[i*WIDTH +: WIDTH];
        sel_sub = bus.req_sub[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sub   <= 1'b0;
      s1_id    <= '0;
    end else if (s1_en) begin
      s1_valid <= any;
      if (any) begin
        s1_a   <= sel_a;
        s1_b   <= sel_b;
        s1_sub <= sel_sub;
        s1_id  <= grant_idx;
      end
    end
  end

  // Subtract is A + ~B + 1, so cout = 1 means no borrow.
  CarryLookaheadAdder #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (s1_a),
    .b    (s1_b ^ {WIDTH{s1_sub}}),
    .cin  (s1_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_id    <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      s2_sum   <= add_sum;
      s2_cout  <= add_cout;
      s2_id    <= s1_id;
    end
  end

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_sum   = s2_sum;
  assign bus.rsp_cout  = s2_cout;
  assign bus.busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Bench for addsub_share_arbiter: directed corner cases plus a random soak,
// checked by an expected-result queue filled on acceptance and drained by a monitor.
module tb_addsub_share_arbiter;
  import addsub_share_arbiter_pkg::*;

  localparam int N  = NUM_REQ_DEF;
  localparam int W  = WIDTH_DEF;
  localparam int IW = ID_W_DEF;
  localparam int EW = IW + W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  addsub_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic: packed as {id, sum, cout}.
  function automatic logic [EW-1:0] model(input int id, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic sub);
    logic [63:0] ua, ub, r;
    logic        c;
    ua = 64'(a);
    ub = 64'(b);
    if (sub) begin
      r = ua - ub;
      c = (ua >= ub);
    end else begin
      r = ua + ub;
      c = r[W];
    end
    return {IW'(id), r[W-1:0], c};
  endfunction

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [IW-1:0] id_log[$];
  int            ptr_m = 0;
  int            acc_cnt = 0;
  int            rsp_cnt = 0;
  int            post_rst_first = -1;
  int            wait_cnt[N];

  // Acceptance tracker: checks req_ready against a round-robin model and queues results.
  int            g_m;
  int            h_m;
  logic          room_m;
  logic [N-1:0]  exp_ready;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      check("reset_req_ready", 64'(bus.req_ready), 64'(0));
      exp_q.delete();
      ptr_m = 0;
      post_rst_first = -1;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      room_m = bus.rsp_ready || (exp_q.size() < 2);
      g_m = -1;
      for (int k = 0; k < N; k++) begin
        if (g_m < 0 && bus.req_valid[(ptr_m + k) % N]) g_m = (ptr_m + k) % N;
      end
      exp_ready = (g_m >= 0 && room_m) ? (N'(1) << g_m) : '0;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      h_m = -1;
      for (int k = 0; k < N; k++) begin
        if (h_m < 0 && bus.req_valid[k] && bus.req_ready[k]) h_m = k;
      end
      if (h_m >= 0) begin
        exp_q.push_back(model(h_m, bus.req_a[h_m*W +: W], bus.req_b[h_m*W +: W], bus.req_sub[h_m]));
        check("starvation", 64'(wait_cnt[h_m] <= N - 1), 64'(1));
        for (int i = 0; i < N; i++) begin
          if (i != h_m && bus.req_valid[i]) wait_cnt[i]++;
        end
        wait_cnt[h_m] = 0;
        ptr_m = (h_m + 1) % N;
        acc_cnt++;
        if (post_rst_first < 0) post_rst_first = h_m;
      end
    end
  end

  // Response monitor: pops the expected queue whenever a result is taken.
  logic          held = 1'b0;
  logic [EW-1:0] held_v;
  logic [EW-1:0] exp_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("reset_busy", 64'(bus.busy), 64'(0));
      check("reset_rsp_data", 64'({bus.rsp_id, bus.rsp_sum, bus.rsp_cout}), 64'(0));
      held = 1'b0;
    end else begin
      check("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
      if (held) begin
        check("hold_valid", 64'(bus.rsp_valid), 64'(1));
        check("hold_data", 64'({bus.rsp_id, bus.rsp_sum, bus.rsp_cout}), 64'(held_v));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_cnt++;
        id_log.push_back(bus.rsp_id);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h with nothing outstanding at %0t",
                   bus.rsp_id, bus.rsp_sum, $time);
        end else begin
          exp_e = exp_q.pop_front();
          check("rsp_id", 64'(bus.rsp_id), 64'(exp_e[EW-1 -: IW]));
          check("rsp_sum", 64'(bus.rsp_sum), 64'(exp_e[W:1]));
          check("rsp_cout", 64'(bus.rsp_cout), 64'(exp_e[0]));
        end
      end
      held   = bus.rsp_valid && !bus.rsp_ready;
      held_v = {bus.rsp_id, bus.rsp_sum, bus.rsp_cout};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_ops(input int i);
    logic [W-1:0] a, b;
    int           m;
    m = $urandom_range(0, 4);
    case (m)
      0: begin a = '1; b = W'($urandom); end
      1: begin a = W'($urandom); b = a; end
      2: begin a = W'($urandom_range(0, 7)); b = W'($urandom_range(0, 7)); end
      default: begin a = W'($urandom); b = W'($urandom); end
    endcase
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_sub[i]      = 1'($urandom_range(0, 1));
  endtask

  // Each cycle: note handshakes, then after the edge refresh idle/served requesters.
  task automatic cycle_drive(input logic [N-1:0] mask, input int vpct, input int rpct, input int ncyc);
    logic [N-1:0] hs;
    repeat (ncyc) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!mask[i]) begin
          bus.req_valid[i] = 1'b0;
        end else if (hs[i] || !bus.req_valid[i]) begin
          if ($urandom_range(1, 100) <= vpct) begin
            new_ops(i);
            bus.req_valid[i] = 1'b1;
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      bus.rsp_ready = ($urandom_range(1, 100) <= rpct);
    end
  endtask

  task automatic send_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic done;
    @(posedge clk);
    #1;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_sub[i]      = sub;
    bus.req_valid       = N'(1) << i;
    bus.rsp_ready       = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge clk);
      done = bus.req_valid[i] && bus.req_ready[i];
    end
    check("send_one_accept", 64'(done), 64'(1));
    @(posedge clk);
    #1;
    bus.req_valid = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int acc0;
  int rsp0;
  initial begin
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    @(posedge clk);
    #2;
    bus.req_valid = '0;
    rst_n = 1'b1;

    // First transaction latency: 5 - 3.
    @(posedge clk);
    #1;
    bus.req_a[0 +: W] = W'(5);
    bus.req_b[0 +: W] = W'(3);
    bus.req_sub[0]    = 1'b1;
    bus.req_valid     = 4'b0001;
    bus.rsp_ready     = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    check("lat_after_accept", 64'(bus.rsp_valid), 64'(0));
    @(posedge clk);
    #1;
    check("lat_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    check("lat_rsp_id", 64'(bus.rsp_id), 64'(0));
    check("lat_rsp_sum", 64'(bus.rsp_sum), 64'(2));
    check("lat_rsp_cout", 64'(bus.rsp_cout), 64'(1));

    // Arithmetic edges.
    send_one(1, 25'h1FFFFFF, 25'd1, 1'b0);
    @(posedge clk);
    #1;
    check("wrap_sum", 64'(bus.rsp_sum), 64'(0));
    check("wrap_cout", 64'(bus.rsp_cout), 64'(1));
    send_one(2, 25'd3, 25'd5, 1'b1);
    send_one(3, 25'h0ABCDEF, 25'h0ABCDEF, 1'b1);

    // Round-robin with everybody requesting.
    cycle_drive('0, 0, 100, 4);
    id_log.delete();
    cycle_drive('1, 100, 100, 12);
    check("rr_log_len", 64'(id_log.size() >= 8), 64'(1));
    for (int k = 0; k < 8 && k < id_log.size(); k++) check("rr_seq", 64'(id_log[k]), 64'(k % N));
    rsp0 = rsp_cnt;
    cycle_drive('1, 100, 100, 8);
    check("rr_throughput", 64'(rsp_cnt - rsp0), 64'(8));

    // Requester 1 drops out: remaining order cycles 0,2,3.
    id_log.delete();
    cycle_drive(4'b1101, 100, 100, 10);
    check("drop_log_len", 64'(id_log.size() >= 6), 64'(1));
    for (int k = 3; k + 1 < id_log.size(); k++) begin
      check("drop_seq", 64'(id_log[k+1]),
            64'((id_log[k] == 0) ? 2 : (id_log[k] == 2) ? 3 : 0));
    end

    // Backpressure: only two entries fit.
    cycle_drive('0, 0, 100, 4);
    acc0 = acc_cnt;
    cycle_drive(4'b0011, 100, 0, 5);
    check("bp_accepted", 64'(acc_cnt - acc0), 64'(2));
    check("bp_req_ready", 64'(bus.req_ready), 64'(0));
    id_log.delete();
    cycle_drive('0, 0, 100, 4);
    check("bp_drain_count", 64'(id_log.size()), 64'(2));

    // Reset pulse with both stages full.
    cycle_drive('1, 100, 0, 3);
    check("midrst_full", 64'(bus.busy && bus.rsp_valid), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_req_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk);
    #2;
    bus.req_valid = '1;
    rst_n = 1'b1;
    cycle_drive('1, 100, 100, 6);
    check("midrst_first_grant", 64'(post_rst_first), 64'(0));

    // Random soak, then drain.
    cycle_drive('1, 60, 70, 10000);
    cycle_drive('0, 0, 100, 6);
    check("soak_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_share_arbiter.md
Name: addsub_share_arbiter

Overview:
- Shares one WIDTH-bit integer adder/subtractor between NUM_REQ requesters, such as the mantissa-alignment and accumulate paths of neighbouring systolic PEs.
- Selects requesters with a round-robin arbiter.
- Registers the granted operands, computes A±B, and returns a tagged result on a single backpressured response port.
- Two-stage pipeline; sustains one operation per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- WIDTH, 25, operand/result width in bits.
- ID_W, $clog2(NUM_REQ), requester tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_sub  in  NUM_REQ  1 = A−B, 0 = A+B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of the requester owning the result.
- rsp_sum  out  WIDTH  result modulo 2^WIDTH.
- rsp_cout  out  1  carry out; for subtract, 1 = no borrow (A ≥ B unsigned).
- busy  out  1  high when either pipeline stage holds a valid entry.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low.
- While rst_n = 0:
  - s1_valid, s2_valid, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy are all 0.
  - RR pointer is 0.
  - req_ready is forced to 0.
- Reset mid-operation discards all in-flight entries; no response is produced for them.
- Stage S1 (operand register: s1_valid, a, b, sub, id).
- Stage S2 (result register: s2_valid, sum, cout, id). rsp_* outputs are driven directly from S2.
- s2_en = !s2_valid | rsp_ready.
  - On a clock edge with s2_en: s2_valid ← s1_valid; sum/cout/id ← adder(S1).
- s1_en = !s1_valid | s2_en.
  - On a clock edge with s1_en: s1_valid ← |req_valid; S1 captures the granted requester's a, b, sub and index.
- Arithmetic: sum = A + (B ^ {WIDTH{sub}}) + sub. cout is the carry out of bit WIDTH−1. Purely combinational between S1 and S2.
- Arbitration (combinational):
  - grant = first i with req_valid[i], scanning ptr, ptr+1, …, NUM_REQ−1, 0, …, ptr−1.
  - req_ready[grant] = s1_en; all other req_ready bits = 0.
  - req_ready never depends on req_valid of the same requester except through the grant selection.
- Pointer update: on a handshake (req_valid[g] & req_ready[g]), ptr ← (g+1) mod NUM_REQ. Without a handshake, ptr holds.
- Latency: a request accepted at edge k gives rsp_valid = 1 after edge k+1, provided rsp_ready was high or S2 was empty at k+1.
- Throughput: one result per cycle while rsp_ready = 1.
- Backpressure:
  - When rsp_valid & !rsp_ready, S2 holds and rsp_* stay stable.
  - S1 holds if it is full.
  - req_ready drops to 0 only when both stages are full and rsp_ready = 0.
  - No entry is lost or duplicated.
- Simultaneous events: when S2 drains and S1 refills in the same edge, both happen (full pipelined flow).
- Requester contract: a requester keeps req_valid and its operands stable until its handshake. The arbiter makes no check of this.
- No reordering: responses appear in acceptance order.
- busy = s1_valid | s2_valid.

Decomposition:
- Shared package holds:
  - default NUM_REQ and WIDTH;
  - ID_W computed with $clog2;
  - localparam MANT_ADD_W = 25 and EXP_ADD_W = 8, for configuring instances that front the mantissa and exponent adders.
- Sub-module rr_arbiter (NUM_REQ): inputs req, advance, adv_idx; outputs grant_onehot, grant_idx, any; contains the ptr register.
- Datapath: instance of CarryLookaheadAdder #(WIDTH) with B pre-XORed by sub and Cin = sub. For WIDTH = 25 this is bit-identical to Adder_Subtractor25.

Test Plan:
- Reset values: assert rst_n = 0 with all req_valid = 1 → req_ready = 0, rsp_valid = 0, busy = 0. Release, then req0 a=5, b=3, sub=1, rsp_ready=1 → two edges later rsp_valid=1, rsp_id=0, rsp_sum=2, rsp_cout=1.
- Arithmetic edges (WIDTH=25):
  - a=0x1FFFFFF, b=1, add → sum=0, cout=1.
  - a=3, b=5, sub → sum=0x1FFFFFE, cout=0.
  - a=b=0x0ABCDEF, sub → sum=0, cout=1.
- Round-robin: all 4 requesters hold valid continuously with rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1,… with one result per cycle. Then drop req1 → sequence 0,2,3,0.
- Backpressure: rsp_ready=0 for 5 cycles with 2 requesters active → exactly 2 accepted (S1+S2 full), then req_ready = 0 and rsp_* stable. Raise rsp_ready → results drain in acceptance order with no gaps and no duplicates.
- Reset mid-flight: with both stages full, pulse rst_n low for 1 cycle → rsp_valid falls immediately (asynchronous), ptr=0, the first grant after release goes to requester 0, and no stale results appear.
- Random soak: 10k cycles of random valid/rsp_ready compared against a scoreboard model → every accepted request is returned exactly once, in order, with correct sum/cout, and no requester waits more than NUM_REQ grants.
